// File: rtl/si5324_i2c_master.sv
// Byte-level I2C write engine for the SI5324 / I2C-mux programming bus.
// One command = START, {dev,W}, reg, data with ACK checks, then STOP; open-drain via output enables.
module si5324_i2c_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic       nack,
    output logic       busy,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [11:0] CNT_LAST = 12'(CLK_DIV - 1);
    // Released SCL needs two synchronizer cycles to read back high, so the
    // stretch check sits on count 2 rather than count 0.
    localparam logic [11:0] CNT_STRETCH = 12'd2;

    logic [2:0]  state_q, state_d;
    logic [1:0]  quarter_q, quarter_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [1:0]  bytecnt_q, bytecnt_d;
    logic [23:0] shift_q, shift_d;
    logic        nack_q, nack_d;
    logic        done_q, busy_q, cmd_ready_q;
    logic        scl_oe_q, sda_oe_q;
    logic        scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic        scl_low_d, sda_low_d;
    logic        accept, stretch, tick;

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign nack      = nack_q;
    assign busy      = busy_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

    always_comb begin
        state_d   = state_q;
        quarter_d = quarter_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        bytecnt_d = bytecnt_q;
        shift_d   = shift_q;
        nack_d    = nack_q;
        accept    = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
        stretch   = (state_q != S_IDLE) && (state_q != S_DONE) && !scl_oe_q &&
                    (cnt_q == CNT_STRETCH) && !scl_s2_q;
        tick      = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    quarter_d = 2'd0;
                    cnt_d     = 12'd0;
                    bitcnt_d  = 3'd0;
                    bytecnt_d = 2'd0;
                    shift_d   = {cmd_dev, 1'b0, cmd_reg, cmd_data};
                    nack_d    = 1'b0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (!stretch) begin
                    if (!tick) begin
                        cnt_d = cnt_q + 12'd1;
                    end else begin
                        cnt_d     = 12'd0;
                        quarter_d = quarter_q + 2'd1;
                        if ((state_q == S_ACK) && (quarter_q == 2'd1) && sda_s2_q) begin
                            nack_d = 1'b1;
                        end
                        if (quarter_q == 2'd3) begin
                            case (state_q)
                                S_START: begin
                                    state_d  = S_BIT;
                                    bitcnt_d = 3'd0;
                                end
                                S_BIT: begin
                                    shift_d  = {shift_q[22:0], 1'b0};
                                    bitcnt_d = bitcnt_q + 3'd1;
                                    if (bitcnt_q == 3'd7) begin
                                        state_d = S_ACK;
                                    end
                                end
                                S_ACK: begin
                                    // A NACK abandons the remaining bytes.
                                    if (nack_q || (bytecnt_q == 2'd2)) begin
                                        state_d = S_STOP;
                                    end else begin
                                        state_d   = S_BIT;
                                        bytecnt_d = bytecnt_q + 2'd1;
                                    end
                                end
                                S_STOP:  state_d = S_DONE;
                                default: state_d = S_IDLE;
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    // Line levels derived from the next state so the registered enables line up with the quarter.
    always_comb begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        case (state_d)
            S_START: begin
                scl_low_d = (quarter_d == 2'd3);
                sda_low_d = quarter_d[1];
            end
            S_BIT: begin
                scl_low_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
                sda_low_d = !shift_d[23];
            end
            S_ACK: begin
                scl_low_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
                sda_low_d = 1'b0;
            end
            S_STOP: begin
                scl_low_d = (quarter_d == 2'd0);
                sda_low_d = !quarter_d[1];
            end
            default: begin
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            quarter_q   <= 2'd0;
            cnt_q       <= 12'd0;
            bitcnt_q    <= 3'd0;
            bytecnt_q   <= 2'd0;
            shift_q     <= 24'd0;
            nack_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            quarter_q   <= quarter_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            bytecnt_q   <= bytecnt_d;
            shift_q     <= shift_d;
            nack_q      <= nack_d;
            done_q      <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
            cmd_ready_q <= (state_d == S_IDLE);
            scl_oe_q    <= scl_low_d;
            sda_oe_q    <= sda_low_d;
            scl_s1_q    <= scl_in;
            scl_s2_q    <= scl_s1_q;
            sda_s1_q    <= sda_in;
            sda_s2_q    <= sda_s1_q;
        end
    end

endmodule

// File: tb/tb_si5324_i2c_master.sv
// Bench for si5324_i2c_master: open-drain bus with a behavioural slave that decodes bytes,
// ACKs or NACKs selectively, and can stretch SCL.
module tb_si5324_i2c_master;

    localparam int D    = 8;
    localparam int FULL = 116 * D + 1;

    typedef struct {
        logic [6:0]  dev;
        logic [7:0]  rg;
        logic [7:0]  dt;
        int          nackByte;
        logic        expNack;
        int          expCycles;
        int          expNbytes;
        logic [23:0] expBytes;
        int          expPulses;
    } vec_t;

    logic       clk50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_dev = 7'd0;
    logic [7:0] cmd_reg = 8'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       done, nack, busy;
    logic       scl_oe, sda_oe;
    logic       scl_line, sda_line;
    logic       slave_scl_low = 1'b0;
    logic       slave_sda_low = 1'b0;

    int nChecks = 0;
    int nErrors = 0;
    int cyc = 0;
    int accCyc = 0;
    int nack_byte = -1;

    // Slave model state; written only by the slave process.
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic       active = 1'b0, pend_ack = 1'b0, in_ack = 1'b0;
    logic [7:0] shreg = 8'd0;
    int         bitn = 0, byteidx = 0;
    int         capn = 0, pulses = 0, stop_cnt = 0;
    logic [7:0] cap [0:255];
    int         capBase = 0, pulseBase = 0, stopBase = 0;

    assign scl_line = !(scl_oe || slave_scl_low);
    assign sda_line = !(sda_oe || slave_sda_low);

    si5324_i2c_master #(.CLK_DIV(D)) dut (
        .clk50     (clk50),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dev   (cmd_dev),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .done      (done),
        .nack      (nack),
        .busy      (busy),
        .scl_in    (scl_line),
        .sda_in    (sda_line),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe)
    );

    always #10 clk50 = ~clk50;

    always @(posedge clk50) cyc <= cyc + 1;

    always @(negedge clk50) begin
        if (prev_scl && scl_line && prev_sda && !sda_line) begin
            active   = 1'b1;
            bitn     = 0;
            byteidx  = 0;
            pend_ack = 1'b0;
            in_ack   = 1'b0;
        end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
            active   = 1'b0;
            stop_cnt = stop_cnt + 1;
        end
        if (!prev_scl && scl_line) begin
            pulses = pulses + 1;
            if (active && !in_ack) begin
                shreg = {shreg[6:0], sda_line};
                bitn  = bitn + 1;
                if (bitn == 8) begin
                    cap[capn[7:0]] = shreg;
                    capn     = capn + 1;
                    pend_ack = 1'b1;
                    bitn     = 0;
                end
            end
        end
        if (prev_scl && !scl_line && active) begin
            if (pend_ack) begin
                pend_ack      = 1'b0;
                in_ack        = 1'b1;
                slave_sda_low = (byteidx != nack_byte);
                byteidx       = byteidx + 1;
            end else if (in_ack) begin
                in_ack        = 1'b0;
                slave_sda_low = 1'b0;
            end
        end
        prev_scl = scl_line;
        prev_sda = sda_line;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks = nChecks + 1;
        if (actual !== expected) begin
            nErrors = nErrors + 1;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dt);
        @(negedge clk50);
        capBase   = capn;
        pulseBase = pulses;
        stopBase  = stop_cnt;
        cmd_dev   = dev;
        cmd_reg   = rg;
        cmd_data  = dt;
        cmd_valid = 1'b1;
        @(negedge clk50);
        cmd_valid = 1'b0;
        accCyc    = cyc;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        checkOutput("ready_after_accept", 32'(cmd_ready), 32'd0);
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                cycles = cyc - accCyc + 1;
                break;
            end
            @(negedge clk50);
        end
        if (cycles < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkResult(input string tag, input vec_t v, input int cycles);
        checkOutput({tag, "_cycles"}, 32'(cycles), 32'(v.expCycles));
        checkOutput({tag, "_nack_at_done"}, 32'(nack), 32'(v.expNack));
        repeat (3) @(negedge clk50);
        checkOutput({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
        checkOutput({tag, "_nack_held"}, 32'(nack), 32'(v.expNack));
        checkOutput({tag, "_nbytes"}, 32'(capn - capBase), 32'(v.expNbytes));
        for (int i = 0; i < v.expNbytes; i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(cap[8'(capBase + i)]), 32'(v.expBytes[23 - 8 * i -: 8]));
        end
        checkOutput({tag, "_scl_pulses"}, 32'(pulses - pulseBase), 32'(v.expPulses));
        checkOutput({tag, "_stops"}, 32'(stop_cnt - stopBase), 32'd1);
    endtask

    task automatic runVector(input string tag, input vec_t v);
        int cycles;
        nack_byte = v.nackByte;
        applyStimulus(v.dev, v.rg, v.dt);
        waitDone(3000, cycles);
        checkResult(tag, v, cycles);
    endtask

    initial begin
        vec_t vecs [5];
        vec_t base;
        int   cycles;

        vecs[0] = '{7'h68, 8'h88, 8'h80, -1, 1'b0, FULL,       3, 24'hD08880, 28};
        vecs[1] = '{7'h68, 8'h88, 8'h80,  0, 1'b1, 44 * D + 1, 1, 24'hD00000, 10};
        vecs[2] = '{7'h68, 8'h88, 8'h80,  2, 1'b1, FULL,       3, 24'hD08880, 28};
        vecs[3] = '{7'h68, 8'h88, 8'h80,  1, 1'b1, 80 * D + 1, 2, 24'hD08800, 19};
        vecs[4] = '{7'h74, 8'h00, 8'h01, -1, 1'b0, FULL,       3, 24'hE80001, 28};
        base    = vecs[0];

        repeat (3) @(negedge clk50);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_nack", 32'(nack), 32'd0);
        checkOutput("rst_scl_oe", 32'(scl_oe), 32'd0);
        checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk50);

        for (int k = 0; k < 5; k++) begin
            runVector($sformatf("vec%0d", k), vecs[k]);
        end

        // SCL held low by the slave for 37 cycles from the q1 release of reg bit 3 (phase 14).
        nack_byte = -1;
        applyStimulus(7'h68, 8'h88, 8'h80);
        while (cyc < accCyc + 57 * D - 2) @(negedge clk50);
        slave_scl_low = 1'b1;
        while (cyc < accCyc + 57 * D + 20) @(negedge clk50);
        checkOutput("stretch_master_released", 32'(scl_oe), 32'd0);
        while (cyc < accCyc + 57 * D + 37) @(negedge clk50);
        slave_scl_low = 1'b0;
        waitDone(3000, cycles);
        checkOutput("stretch_delay_in_range", 32'((cycles >= FULL + 37) && (cycles <= FULL + 40)), 32'd1);
        base.expCycles = cycles;
        checkResult("stretch", base, cycles);
        base.expCycles = FULL;

        // A command offered mid-transaction must be dropped.
        applyStimulus(7'h68, 8'h88, 8'h80);
        repeat (200) @(negedge clk50);
        cmd_dev   = 7'h74;
        cmd_reg   = 8'h00;
        cmd_data  = 8'h01;
        cmd_valid = 1'b1;
        @(negedge clk50);
        cmd_valid = 1'b0;
        waitDone(3000, cycles);
        checkResult("ignore", base, cycles);
        repeat (20) @(negedge clk50);
        checkOutput("ignore_no_restart", 32'(busy), 32'd0);
        checkOutput("ignore_no_extra_bytes", 32'(capn - capBase), 32'd3);

        // Reset during the reg byte (phase 12 q0: SCL low, SDA low for reg bit 5 = 0).
        applyStimulus(7'h68, 8'h88, 8'h80);
        while (cyc < accCyc + 48 * D + 1) @(negedge clk50);
        checkOutput("pre_reset_scl_oe", 32'(scl_oe), 32'd1);
        checkOutput("pre_reset_sda_oe", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_scl_oe", 32'(scl_oe), 32'd0);
        checkOutput("reset_sda_oe", 32'(sda_oe), 32'd0);
        repeat (2) @(negedge clk50);
        rst_n = 1'b1;
        @(negedge clk50);
        checkOutput("post_reset_ready", 32'(cmd_ready), 32'd1);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk50);
        runVector("after_reset", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
